// File: rtl/pcn_dec_pkg.sv
// Shared definitions for the stochastic LDPC decode controller:
// the controller state encoding and the default cycle-budget constants.
package pcn_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MAX_CYC_DEF  = 1024;
    localparam int SAT_HOLD_DEF = 8;

endpackage

// File: rtl/pcn_sat_monitor.sv
// Tracks how long every parity-check node has been satisfied in a row.
// sat_ok flags the cycle on which the run of satisfied cycles reaches SAT_HOLD.
module pcn_sat_monitor #(
    parameter int NUM_PCN  = 6,
    parameter int SAT_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [NUM_PCN-1:0] pc_sat,
    output logic               sat_ok
);

    localparam int SAT_W = $clog2(SAT_HOLD + 1);
    localparam logic [SAT_W-1:0] SAT_LAST = SAT_W'(SAT_HOLD - 1);

    logic             sat_r;
    logic [SAT_W-1:0] sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r   <= 1'b0;
            sat_cnt <= '0;
        end else if (clear) begin
            sat_r   <= 1'b0;
            sat_cnt <= '0;
        end else if (enable) begin
            sat_r <= &pc_sat;
            // Any unsatisfied cycle restarts the run; the count parks at its last value.
            if (!sat_r)
                sat_cnt <= '0;
            else if (sat_cnt != SAT_LAST)
                sat_cnt <= sat_cnt + SAT_W'(1);
        end
    end

    assign sat_ok = sat_r && (sat_cnt == SAT_LAST);

endmodule

// File: rtl/pcn_decode_ctrl.sv
// Decode sequencer: IDLE -> LOAD -> RUN -> DONE, ending early on sustained parity success.
// Optional PCN_DECODE_ABORT_EN adds an abort input that ends RUN immediately without success.
module pcn_decode_ctrl
    import pcn_dec_pkg::*;
#(
    parameter int NUM_PCN  = 6,
    parameter int MAX_CYC  = MAX_CYC_DEF,
    parameter int SAT_HOLD = SAT_HOLD_DEF,
    localparam int CNT_W   = $clog2(MAX_CYC + 1)
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start,
    input  logic [NUM_PCN-1:0] PC_sat,
`ifdef PCN_DECODE_ABORT_EN
    input  logic               abort,
`endif
    output logic               load,
    output logic               run,
    output logic               busy,
    output logic               done,
    output logic               success,
    output logic [CNT_W-1:0]   cyc_count
);

    state_t state;
    state_t next_state;
    logic   sat_ok;
    logic   timeout;
    logic   abort_hit;

`ifdef PCN_DECODE_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign timeout = (cyc_count == CNT_W'(MAX_CYC - 1));

    pcn_sat_monitor #(
        .NUM_PCN  (NUM_PCN),
        .SAT_HOLD (SAT_HOLD)
    ) u_sat_monitor (
        .clk    (CLK),
        .rst_n  (RSTn),
        .clear  (state == LOAD),
        .enable (state == RUN),
        .pc_sat (PC_sat),
        .sat_ok (sat_ok)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        run        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    next_state = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                busy       = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                run  = 1'b1;
                busy = 1'b1;
                if (abort_hit || sat_ok || timeout)
                    next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Result registers stay valid after DONE until the next LOAD wipes them.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cyc_count <= '0;
            success   <= 1'b0;
        end else if (state == LOAD) begin
            cyc_count <= '0;
            success   <= 1'b0;
        end else if (state == RUN) begin
            cyc_count <= cyc_count + CNT_W'(1);
            if (!abort_hit && sat_ok)
                success <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcn_decode_ctrl.sv
// Directed bench for pcn_decode_ctrl with NUM_PCN=6, MAX_CYC=32, SAT_HOLD=8.
// Define PCN_DECODE_ABORT_EN to also exercise the abort input.
module tb_pcn_decode_ctrl;

    logic       CLK;
    logic       RSTn;
    logic       start;
    logic [5:0] PC_sat;
`ifdef PCN_DECODE_ABORT_EN
    logic       abort;
`endif
    logic       load;
    logic       run;
    logic       busy;
    logic       done;
    logic       success;
    logic [5:0] cyc_count;

    int checks;
    int failures;

    pcn_decode_ctrl #(
        .NUM_PCN  (6),
        .MAX_CYC  (32),
        .SAT_HOLD (8)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .start     (start),
        .PC_sat    (PC_sat),
`ifdef PCN_DECODE_ABORT_EN
        .abort     (abort),
`endif
        .load      (load),
        .run       (run),
        .busy      (busy),
        .done      (done),
        .success   (success),
        .cyc_count (cyc_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Pulse (or hold) start from IDLE and check the LOAD/RUN entry timing.
    task automatic start_decode(input bit hold);
        start = 1'b1;
        step();
        checks++;
        if ({load, run, busy, done} !== 4'b1010) begin
            failures++;
            $display("FAIL load_cycle: {load,run,busy,done}=%b expected 1010", {load, run, busy, done});
        end
        if (!hold) start = 1'b0;
        step();
        checks++;
        if ({load, run, busy, done, success, cyc_count} !== {5'b01100, 6'd0}) begin
            failures++;
            $display("FAIL run_entry: {load,run,busy,done,success}=%b cyc=%0d expected 01100 cyc=0",
                     {load, run, busy, done, success}, cyc_count);
        end
    endtask

    // Drive PC_sat per RUN cycle index until run drops; nrun counts RUN cycles seen.
    task automatic run_loop(input int mode, input int abort_at, output int nrun);
        nrun = 0;
        while (run === 1'b1 && nrun < 40) begin
            case (mode)
                0: PC_sat = 6'h3F;
                1: PC_sat = (nrun == 7) ? 6'h3E : 6'h3F;
                2: PC_sat = (nrun % 3 == 0) ? 6'h00 : ((nrun % 3 == 1) ? 6'h3E : 6'h1F);
                default: PC_sat = (nrun >= 23) ? 6'h3F : 6'h00;
            endcase
`ifdef PCN_DECODE_ABORT_EN
            abort = (nrun == abort_at);
`else
            if (abort_at >= 0) PC_sat = 6'h00;
`endif
            step();
            nrun++;
        end
`ifdef PCN_DECODE_ABORT_EN
        abort = 1'b0;
`endif
        PC_sat = 6'h00;
    endtask

    // Check the DONE cycle, then the first IDLE cycle with results held.
    task automatic check_end(input string name, input int nrun, input int exp_n,
                             input bit exp_succ);
        checks++;
        if (nrun != exp_n) begin
            failures++;
            $display("FAIL %s_run_cycles: got %0d expected %0d", name, nrun, exp_n);
        end
        checks++;
        if ({load, run, busy, done, success, cyc_count} !== {4'b0011, exp_succ, 6'(exp_n)}) begin
            failures++;
            $display("FAIL %s_done: {load,run,busy,done,success}=%b cyc=%0d expected 0011%b cyc=%0d",
                     name, {load, run, busy, done, success}, cyc_count, exp_succ, exp_n);
        end
        step();
        checks++;
        if ({load, run, busy, done, success, cyc_count} !== {4'b0000, exp_succ, 6'(exp_n)}) begin
            failures++;
            $display("FAIL %s_hold: {load,run,busy,done,success}=%b cyc=%0d expected 0000%b cyc=%0d",
                     name, {load, run, busy, done, success}, cyc_count, exp_succ, exp_n);
        end
    endtask

    task automatic test_reset();
        RSTn   = 1'b0;
        start  = 1'b0;
        PC_sat = 6'h00;
        repeat (2) step();
        checks++;
        if ({load, run, busy, done, success, cyc_count} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: {load,run,busy,done,success,cyc}=%b expected all 0",
                     {load, run, busy, done, success, cyc_count});
        end
        RSTn = 1'b1;
        repeat (2) step();
        checks++;
        if ({load, run, busy, done, success, cyc_count} !== 11'd0) begin
            failures++;
            $display("FAIL idle_after_reset: {load,run,busy,done,success,cyc}=%b expected all 0",
                     {load, run, busy, done, success, cyc_count});
        end
    endtask

    task automatic test_fast_success();
        int n;
        start_decode(1'b0);
        run_loop(0, -1, n);
        check_end("fast_success", n, 9, 1'b1);
    endtask

    task automatic test_restart();
        int n;
        start_decode(1'b0);
        run_loop(1, -1, n);
        check_end("restart", n, 17, 1'b1);
    endtask

    task automatic test_timeout();
        int n;
        start_decode(1'b0);
        run_loop(2, -1, n);
        check_end("timeout", n, 32, 1'b0);
    endtask

    task automatic test_late_success();
        int n;
        start_decode(1'b0);
        run_loop(3, -1, n);
        check_end("late_success", n, 32, 1'b1);
    endtask

    // Relaunch on the very first IDLE cycle after a timeout, then a success.
    task automatic test_back_to_back();
        int n;
        start_decode(1'b0);
        run_loop(2, -1, n);
        check_end("b2b_first", n, 32, 1'b0);
        start_decode(1'b0);
        run_loop(0, -1, n);
        check_end("b2b_second", n, 9, 1'b1);
    endtask

    task automatic test_start_ignored();
        int n;
        start_decode(1'b1);
        run_loop(0, -1, n);
        start = 1'b0;
        check_end("start_held", n, 9, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        start_decode(1'b0);
        PC_sat = 6'h3F;
        repeat (4) step();
        RSTn = 1'b0;
        #1;
        checks++;
        if ({load, run, busy, done, success, cyc_count} !== 11'd0) begin
            failures++;
            $display("FAIL async_abort: {load,run,busy,done,success,cyc}=%b expected all 0",
                     {load, run, busy, done, success, cyc_count});
        end
        saw_done = 1'b0;
        repeat (2) begin
            step();
            if (done === 1'b1) saw_done = 1'b1;
        end
        RSTn = 1'b1;
        repeat (3) begin
            step();
            if (done === 1'b1) saw_done = 1'b1;
        end
        PC_sat = 6'h00;
        checks++;
        if (saw_done || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: saw_done=%b busy=%b expected 0 0", saw_done, busy);
        end
    endtask

`ifdef PCN_DECODE_ABORT_EN
    task automatic test_abort();
        int n;
        start_decode(1'b0);
        run_loop(2, 5, n);
        check_end("abort", n, 6, 1'b0);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        RSTn     = 1'b0;
        start    = 1'b0;
        PC_sat   = 6'h00;
`ifdef PCN_DECODE_ABORT_EN
        abort    = 1'b0;
`endif
        test_reset();
        test_fast_success();
        test_restart();
        test_timeout();
        test_late_success();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_fast_success();
`ifdef PCN_DECODE_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pcn_decode_ctrl.md
# pcn_decode_ctrl

Sequencing controller for the stochastic LDPC decoder array.
- Starts a decode on request: pulses `load` so the variable nodes latch channel probabilities, then holds `run` high while the parity-check nodes iterate.
- Watches every parity-check node's satisfied flag and ends the decode early once all checks hold for `SAT_HOLD` consecutive cycles; otherwise it ends on timeout after `MAX_CYC` cycles.
- Sits between the top-level frame interface and the variable-node / parity-check-node fabric.

## Interface
Parameters:
- `NUM_PCN`, 6 — number of parity-check nodes monitored.
- `MAX_CYC`, 1024 — decode cycle budget (RUN cycles before timeout); ≥ 2.
- `SAT_HOLD`, 8 — consecutive all-satisfied cycles required for success; 1 ≤ `SAT_HOLD` ≤ `MAX_CYC`.
- `CNT_W` (localparam) = `$clog2(MAX_CYC+1)`.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` input, 1 — clock; all state updates on the rising edge.
- `RSTn` input, 1 — asynchronous active-low reset.
- `start` input, 1 — begin a decode; sampled only in IDLE.
- `PC_sat` input, `NUM_PCN` — per-node parity-check-satisfied flags.
- `load` output, 1 — one-cycle pulse: variable nodes load channel data.
- `run` output, 1 — node update enable during decoding.
- `busy` output, 1 — high in LOAD, RUN and DONE.
- `done` output, 1 — one-cycle pulse at decode end.
- `success` output, 1 — result of the last decode; held until the next LOAD.
- `cyc_count` output, `CNT_W` — RUN cycles used by the current or last decode.

## Operation
States, all registered:
- IDLE: `start=1` → LOAD. Otherwise stay.
- LOAD: `load=1`; clear `cyc_count`, `success`, `sat_r` and `sat_cnt`; → RUN unconditionally.
- RUN: `run=1`. Per-cycle updates:
  - `cyc_count` += 1.
  - `sat_r <= &PC_sat`.
  - `sat_cnt` += 1 when `sat_r=1`; cleared to 0 when `sat_r=0`.
  - Exit priority:
    1. `sat_r=1` and `sat_cnt == SAT_HOLD-1` → DONE with `success` set to 1.
    2. Otherwise, `cyc_count == MAX_CYC-1` → DONE with `success=0`.
  - When success and timeout coincide, success wins.
- DONE: `done=1` for one cycle → IDLE.

Other rules:
- `start` is ignored in LOAD, RUN and DONE.
- `sat_cnt` saturates at `SAT_HOLD-1`.
- Counter arithmetic is unsigned and never wraps, because `CNT_W` holds `MAX_CYC`.
- Reset: all outputs 0, state IDLE, all counters and `sat_r` 0. Reset asserted mid-decode aborts immediately with no `done` pulse.

## Timing
- `start` high at cycle t (IDLE) → `load` and `busy` high at t+1 → `run` high from t+2.
- `sat_r` adds one cycle of latency from `PC_sat` to the decision. It is 0 in the first RUN cycle.
- Minimum success decode: `SAT_HOLD+1` RUN cycles.
- Timeout decode: exactly `MAX_CYC` RUN cycles; final `cyc_count = MAX_CYC`.
- `done` is high the cycle after the last RUN cycle. `success` and `cyc_count` are valid from that cycle until the next LOAD.
- A new `start` can be accepted on the first IDLE cycle after DONE.

## Configuration
- `PCN_DECODE_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort=1` in RUN → DONE next cycle with `success=0`.
  - `abort` has priority over both success and timeout.
  - `abort` is ignored in other states.
- Not defined: no `abort` port; a decode ends only on success or timeout.

## Structure
- Shared package `pcn_dec_pkg` holds the state enum (IDLE, LOAD, RUN, DONE) and the default `MAX_CYC` / `SAT_HOLD` constants.
- One sub-module, `pcn_sat_monitor`:
  - Contains the AND-reduce, the `sat_r` register, the `sat_cnt` saturating counter and its clear/enable inputs.
  - Outputs `sat_ok`.
- The FSM and `cyc_count` stay in `pcn_decode_ctrl`.

## Test plan
All scenarios use `NUM_PCN=6`, `MAX_CYC=32`, `SAT_HOLD=8`.
- Reset: `RSTn=0` → all outputs 0. Release, then `start` pulse → `load` at t+1, `run` from t+2.
- `PC_sat=6'h3F` from the first RUN cycle → 9 RUN cycles, then `done` with `success=1`, `cyc_count=9`.
- `PC_sat=6'h3F` for 7 cycles, then `6'h3E` for 1 cycle, then `6'h3F` → counter restarts; `done` only after 8 new consecutive sat cycles.
- `PC_sat=6'h00` throughout → 32 RUN cycles, then `done` with `success=0`, `cyc_count=32`.
- All-sat condition met exactly on RUN cycle 31 (PC_sat all-high from RUN cycle 23) → `success=1`, `cyc_count=32`.
- `start` held high in RUN → ignored. `RSTn` pulsed low mid-RUN → IDLE, no `done`. With `PCN_DECODE_ABORT_EN` defined, `abort` in RUN cycle 5 → `done` with `success=0`, `cyc_count=6`.
